// File: rtl/fp16_result_serializer.sv
// FP16 result serializer: word FIFO feeding a low-byte-first byte stream.
// Each emitted word carries {nan, inf, zero} flags held for both bytes.
module fp16_result_serializer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               out_byte,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [2:0]               out_flags,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, LO, HI} state_t;

    state_t          state_q, state_d;
    logic [15:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW-1:0]   count_q, count_d;
    logic [7:0]      hi_q, hi_d;
    logic [7:0]      byte_q, byte_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic [2:0]      flags_q, flags_d;
    logic            full, empty, push, pop;
    logic [15:0]     head;

    function automatic logic [2:0] classify(input logic [15:0] w);
        logic [4:0] e;
        logic [9:0] m;
        e = w[14:10];
        m = w[9:0];
        return {(e == 5'd31) && (m != 10'd0),
                (e == 5'd31) && (m == 10'd0),
                (e == 5'd0)};
    endfunction

    assign full     = (count_q == PW'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q];
    // Load in IDLE, or back-to-back from HI once the high byte is taken.
    assign pop      = !empty &&
                      ((state_q == IDLE) || ((state_q == HI) && out_ready));

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hi_q    <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pop) state_d = LO;
            LO:      if (out_ready) state_d = HI;
            HI: begin
                if (out_ready) state_d = pop ? LO : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hi_d    = hi_q;
        byte_d  = byte_q;
        valid_d = valid_q;
        last_d  = last_q;
        flags_d = flags_q;
        if (pop) begin
            hi_d    = head[15:8];
            byte_d  = head[7:0];
            valid_d = 1'b1;
            last_d  = 1'b0;
            flags_d = classify(head);
        end else if ((state_q == LO) && out_ready) begin
            byte_d = hi_q;
            last_d = 1'b1;
        end else if ((state_q == HI) && out_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    assign out_byte  = byte_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_flags = flags_q;
    assign count     = count_q;

endmodule

// File: tb/tb_fp16_result_serializer.sv
// Directed bench for fp16_result_serializer.
// Linear step sequence with immediate assertions at each check.
module tb_fp16_result_serializer;
    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic [2:0]  out_flags;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    fp16_result_serializer #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .out_flags (out_flags),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_step(input logic [15:0] d);
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Check the presented byte, then advance one cycle.
    task automatic expect_byte(input string tag, input logic [7:0] b,
                               input logic l, input logic [2:0] f);
        chk({tag, ".valid"}, 16'(out_valid), 16'd1);
        chk({tag, ".byte"},  16'(out_byte),  16'(b));
        chk({tag, ".last"},  16'(out_last),  16'(l));
        chk({tag, ".flags"}, 16'(out_flags), 16'(f));
        step();
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst.valid", 16'(out_valid), 16'd0);
        chk("rst.last",  16'(out_last),  16'd0);
        chk("rst.byte",  16'(out_byte),  16'h00);
        chk("rst.flags", 16'(out_flags), 16'd0);
        chk("rst.count", 16'(count),     16'd0);
        chk("rst.inrdy", 16'(in_ready),  16'd0);
        rst = 1'b0;
        step();
        chk("post_rst.inrdy", 16'(in_ready), 16'd1);

        // Single word with latency check
        out_ready = 1'b1;
        push_step(16'h3C00);
        chk("single.count1", 16'(count),     16'd1);
        chk("single.nv",     16'(out_valid), 16'd0);
        step();
        chk("single.count0", 16'(count), 16'd0);
        expect_byte("single.lo", 8'h00, 1'b0, 3'b000);
        expect_byte("single.hi", 8'h3C, 1'b1, 3'b000);
        chk("single.done", 16'(out_valid), 16'd0);
        chk("single.cnt",  16'(count),     16'd0);

        // Classification: queue five words under backpressure
        out_ready = 1'b0;
        push_step(16'h7C00);
        push_step(16'hFE01);
        push_step(16'h8000);
        push_step(16'h0001);
        push_step(16'hC500);
        chk("cls.count", 16'(count), 16'd4);
        out_ready = 1'b1;
        expect_byte("cls.inf.lo",  8'h00, 1'b0, 3'b010);
        expect_byte("cls.inf.hi",  8'h7C, 1'b1, 3'b010);
        expect_byte("cls.nan.lo",  8'h01, 1'b0, 3'b100);
        expect_byte("cls.nan.hi",  8'hFE, 1'b1, 3'b100);
        expect_byte("cls.nz.lo",   8'h00, 1'b0, 3'b001);
        expect_byte("cls.nz.hi",   8'h80, 1'b1, 3'b001);
        expect_byte("cls.sub.lo",  8'h01, 1'b0, 3'b001);
        expect_byte("cls.sub.hi",  8'h00, 1'b1, 3'b001);
        expect_byte("cls.norm.lo", 8'h00, 1'b0, 3'b000);
        expect_byte("cls.norm.hi", 8'hC5, 1'b1, 3'b000);
        chk("cls.done", 16'(out_valid), 16'd0);

        // Full FIFO: sixth word must be refused
        out_ready = 1'b0;
        push_step(16'h0001);
        push_step(16'h0002);
        push_step(16'h0003);
        push_step(16'h0004);
        push_step(16'h0005);
        chk("full.count", 16'(count),    16'd4);
        chk("full.inrdy", 16'(in_ready), 16'd0);
        push_step(16'h0006);
        chk("full.count2", 16'(count),    16'd4);
        chk("full.inrdy2", 16'(in_ready), 16'd0);
        out_ready = 1'b1;
        for (int w = 1; w <= 5; w++) begin
            expect_byte("full.lo", 8'(w), 1'b0, 3'b001);
            expect_byte("full.hi", 8'h00, 1'b1, 3'b001);
        end
        chk("full.done",  16'(out_valid), 16'd0);
        chk("full.empty", 16'(count),     16'd0);

        // Backpressure in LO and HI
        out_ready = 1'b0;
        push_step(16'h1234);
        step();
        for (int i = 0; i < 3; i++) begin
            expect_byte("bp.lo", 8'h34, 1'b0, 3'b000);
        end
        out_ready = 1'b1;
        expect_byte("bp.lo_go", 8'h34, 1'b0, 3'b000);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_byte("bp.hi", 8'h12, 1'b1, 3'b000);
        end
        out_ready = 1'b1;
        expect_byte("bp.hi_go", 8'h12, 1'b1, 3'b000);
        chk("bp.done", 16'(out_valid), 16'd0);

        // Concurrent push with HI->LO pop at count=2
        out_ready = 1'b0;
        push_step(16'h1122);
        push_step(16'h3344);
        push_step(16'h5566);
        chk("cc.count2", 16'(count), 16'd2);
        out_ready = 1'b1;
        expect_byte("cc.w1.lo", 8'h22, 1'b0, 3'b000);
        chk("cc.hi_count", 16'(count),    16'd2);
        chk("cc.hi_byte",  16'(out_byte), 16'h11);
        push_step(16'h7788);
        chk("cc.count_kept", 16'(count), 16'd2);
        expect_byte("cc.w2.lo", 8'h44, 1'b0, 3'b000);
        expect_byte("cc.w2.hi", 8'h33, 1'b1, 3'b000);
        expect_byte("cc.w3.lo", 8'h66, 1'b0, 3'b000);
        expect_byte("cc.w3.hi", 8'h55, 1'b1, 3'b000);
        expect_byte("cc.w4.lo", 8'h88, 1'b0, 3'b000);
        expect_byte("cc.w4.hi", 8'h77, 1'b1, 3'b000);
        chk("cc.done", 16'(out_valid), 16'd0);

        // Reset while in HI with three queued words
        out_ready = 1'b0;
        push_step(16'hAAAA);
        push_step(16'hBBBB);
        push_step(16'hCCCC);
        push_step(16'hDDDD);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("mr.in_hi", 16'(out_last), 16'd1);
        chk("mr.count3", 16'(count),   16'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mr.valid", 16'(out_valid), 16'd0);
        chk("mr.last",  16'(out_last),  16'd0);
        chk("mr.count", 16'(count),     16'd0);
        chk("mr.inrdy", 16'(in_ready),  16'd1);
        out_ready = 1'b1;
        push_step(16'h4000);
        step();
        expect_byte("mr.new.lo", 8'h00, 1'b0, 3'b000);
        expect_byte("mr.new.hi", 8'h40, 1'b1, 3'b000);
        for (int i = 0; i < 3; i++) begin
            chk("mr.quiet", 16'(out_valid), 16'd0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
